// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation codes
// and the width of the mode field.
package shift_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'd0,
    MODE_SHL  = 3'd1,
    MODE_SHR  = 3'd2,
    MODE_ROL  = 3'd3,
    MODE_ROR  = 3'd4,
    MODE_LOAD = 3'd5,
    MODE_CLR  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

endpackage

// File: rtl/shift_frame_counter.sv
// Frame counter for the universal shift register. Counts shift/rotate
// operations and emits a registered one-cycle frame_done pulse on the edge
// that completes every WIDTH-th operation. clr restarts the frame.
module shift_frame_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic frame_done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;

  // Next count: restart on clr, advance on inc, wrap and pulse at the last bit.
  always_comb begin
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and pulse registers; reset clears them without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register: shift left/right, rotate left/right, parallel
// load and clear, with a frame counter pulsing after every WIDTH
// shift/rotate operations. All outputs come straight from flops.
module shift_register_universal
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              sin_r,
  input  logic              sin_l,
  input  logic [WIDTH-1:0]  pdata_in,
  output logic [WIDTH-1:0]  pdata_out,
  output logic              sout_msb,
  output logic              sout_lsb,
  output logic              frame_done
);

  mode_e            mode_sel;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cnt_clr, cnt_inc;

  assign mode_sel = mode_e'(mode);

  // Mode mux: next register contents for the selected operation.
  always_comb begin
    data_d = data_q;
    if (en) begin
      case (mode_sel)
        MODE_SHL:  data_d = {data_q[WIDTH-2:0], sin_r};
        MODE_SHR:  data_d = {sin_l, data_q[WIDTH-1:1]};
        MODE_ROL:  data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        MODE_ROR:  data_d = {data_q[0], data_q[WIDTH-1:1]};
        MODE_LOAD: data_d = pdata_in;
        MODE_CLR:  data_d = '0;
        default:   data_d = data_q;
      endcase
    end
  end

  // Counter control: load/clear restart the frame, shifts/rotates advance it.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (en) begin
      case (mode_sel)
        MODE_LOAD, MODE_CLR: cnt_clr = 1'b1;
        MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: cnt_inc = 1'b1;
        default: ;
      endcase
    end
  end

  // Data register; asynchronous reset to RESET_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  shift_frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .frame_done (frame_done)
  );

  assign pdata_out = data_q;
  assign sout_msb  = data_q[WIDTH-1];
  assign sout_lsb  = data_q[0];

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal (WIDTH=8, RESET_VAL=0).
module tb_shift_register_universal;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_SHL  = 3'd1;
  localparam logic [2:0] M_SHR  = 3'd2;
  localparam logic [2:0] M_ROL  = 3'd3;
  localparam logic [2:0] M_ROR  = 3'd4;
  localparam logic [2:0] M_LOAD = 3'd5;
  localparam logic [2:0] M_CLR  = 3'd6;
  localparam logic [2:0] M_RSVD = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] pdata_in;
  logic [7:0] pdata_out;
  logic       sout_msb;
  logic       sout_lsb;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rol_exp [8];
  logic [7:0] ror_exp [8];
  logic [7:0] shl_exp [8];
  logic [7:0] shr_exp [8];

  shift_register_universal #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .sin_r      (sin_r),
    .sin_l      (sin_l),
    .pdata_in   (pdata_in),
    .pdata_out  (pdata_out),
    .sout_msb   (sout_msb),
    .sout_lsb   (sout_lsb),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step(input logic e, input logic [2:0] m, input logic sr,
                      input logic sl, input logic [7:0] pd);
    en       = e;
    mode     = m;
    sin_r    = sr;
    sin_l    = sl;
    pdata_in = pd;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rol_exp = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    ror_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    shl_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
    shr_exp = '{8'h1E, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00};

    rst_n = 1'b0; en = 1'b0; mode = M_HOLD; sin_r = 1'b0; sin_l = 1'b0; pdata_in = 8'h00;
    #2;
    check("reset_pdata", pdata_out, 8'h00);
    check("reset_fd", {7'b0, frame_done}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Asynchronous reset between edges
    step(1'b1, M_LOAD, 1'b0, 1'b0, 8'hFF);
    check("load_ff", pdata_out, 8'hFF);
    check("load_ff_msb", {7'b0, sout_msb}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("async_rst_pdata", pdata_out, 8'h00);
    check("async_rst_fd", {7'b0, frame_done}, 8'h00);
    en = 1'b1; mode = M_LOAD; pdata_in = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_hold_pdata", pdata_out, 8'h00);
    rst_n = 1'b1;

    // Single shifts
    step(1'b1, M_LOAD, 1'b0, 1'b0, 8'hA5);
    step(1'b1, M_SHL, 1'b1, 1'b0, 8'h00);
    check("shl", pdata_out, 8'h4B);
    check("shl_msb", {7'b0, sout_msb}, 8'h00);
    step(1'b1, M_LOAD, 1'b0, 1'b0, 8'hA5);
    step(1'b1, M_SHR, 1'b0, 1'b1, 8'h00);
    check("shr", pdata_out, 8'hD2);
    check("shr_lsb", {7'b0, sout_lsb}, 8'h00);

    // Clear
    step(1'b1, M_LOAD, 1'b0, 1'b0, 8'h5A);
    step(1'b1, M_CLR, 1'b1, 1'b1, 8'hFF);
    check("clr", pdata_out, 8'h00);

    // Rotate frame
    step(1'b1, M_LOAD, 1'b0, 1'b0, 8'h81);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, M_ROL, 1'b0, 1'b0, 8'h00);
      check($sformatf("rol_val%0d", i), pdata_out, rol_exp[i]);
      check($sformatf("rol_fd%0d", i), {7'b0, frame_done}, (i == 7) ? 8'h01 : 8'h00);
    end
    step(1'b1, M_HOLD, 1'b0, 1'b0, 8'h00);
    check("rol_fd_drop", {7'b0, frame_done}, 8'h00);
    check("hold_val", pdata_out, 8'h81);

    // Enable low and reserved mode
    for (int i = 0; i < 3; i++) begin
      step(1'b0, M_SHL, 1'b1, 1'b1, 8'hFF);
      check($sformatf("en0_val%0d", i), pdata_out, 8'h81);
      check($sformatf("en0_fd%0d", i), {7'b0, frame_done}, 8'h00);
    end
    step(1'b1, M_RSVD, 1'b1, 1'b1, 8'hFF);
    check("rsvd_val", pdata_out, 8'h81);
    check("rsvd_fd", {7'b0, frame_done}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, M_SHL, 1'b0, 1'b0, 8'h00);
      check($sformatf("post_en_val%0d", i), pdata_out, shl_exp[i]);
      check($sformatf("post_en_fd%0d", i), {7'b0, frame_done}, (i == 7) ? 8'h01 : 8'h00);
    end

    // Mid-frame reload restarts the count
    step(1'b1, M_LOAD, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, M_SHL, 1'b0, 1'b0, 8'h00);
      check($sformatf("pre_reload_fd%0d", i), {7'b0, frame_done}, 8'h00);
    end
    step(1'b1, M_LOAD, 1'b0, 1'b0, 8'h3C);
    check("reload_val", pdata_out, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, M_SHR, 1'b1, 1'b0, 8'h00);
      check($sformatf("reload_val%0d", i), pdata_out, shr_exp[i]);
      check($sformatf("reload_fd%0d", i), {7'b0, frame_done}, (i == 7) ? 8'h01 : 8'h00);
    end

    // Back-to-back frames
    step(1'b1, M_LOAD, 1'b0, 1'b0, 8'h01);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, M_ROR, 1'b0, 1'b0, 8'h00);
      check($sformatf("ror_val%0d", i), pdata_out, ror_exp[i % 8]);
      check($sformatf("ror_fd%0d", i), {7'b0, frame_done}, ((i % 8) == 7) ? 8'h01 : 8'h00);
    end

    // Reset mid-frame clears the count
    for (int i = 0; i < 3; i++) step(1'b1, M_ROR, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_val", pdata_out, 8'h00);
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, M_SHL, 1'b1, 1'b0, 8'h00);
      check($sformatf("after_rst_fd%0d", i), {7'b0, frame_done}, (i == 7) ? 8'h01 : 8'h00);
    end
    check("after_rst_val", pdata_out, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_register_universal.md
# shift_register_universal

Parametrised universal shift register: the successor to the fixed 4-bit serial-in/serial-out shifter. It adds configurable width, bidirectional shift, rotate, parallel load and synchronous clear, plus a frame counter that pulses after every WIDTH shift/rotate operations. The block is the common serialiser/deserialiser building block for serial links and bit-stream formatting logic elsewhere in the design.

## Interface
- WIDTH, 8: register width in bits; legal range WIDTH ≥ 2.
- RESET_VAL, {WIDTH{1'b0}}: register contents after reset.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  1  operation enable; when low, the register and counter hold.
- mode  input  3  operation select, sampled when en=1.
- sin_r  input  1  serial input entering bit 0 on a left shift.
- sin_l  input  1  serial input entering bit WIDTH-1 on a right shift.
- pdata_in  input  WIDTH  parallel load data.
- pdata_out  output  WIDTH  current register contents.
- sout_msb  output  1  equals pdata_out[WIDTH-1]; serial output for left shift.
- sout_lsb  output  1  equals pdata_out[0]; serial output for right shift.
- frame_done  output  1  single-cycle pulse after WIDTH shift/rotate operations.

## Operation
- Mode encoding: 0 HOLD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 LOAD, 6 CLR, 7 reserved (behaves as HOLD).
- SHL: reg ← {reg[WIDTH-2:0], sin_r}.
- SHR: reg ← {sin_l, reg[WIDTH-1:1]}.
- ROL: reg ← {reg[WIDTH-2:0], reg[WIDTH-1]}.
- ROR: reg ← {reg[0], reg[WIDTH-1:1]}.
- LOAD: reg ← pdata_in. CLR: reg ← 0. Neither uses RESET_VAL.
- Frame counter cnt, width $clog2(WIDTH):
  - LOAD and CLR set cnt to 0.
  - SHL, SHR, ROL and ROR increment cnt.
  - HOLD, reserved and en=0 leave cnt unchanged.
  - Shift/rotate with cnt = WIDTH-1 wraps cnt to 0 and registers frame_done=1.
- frame_done is 0 on every other cycle, including while en=0. It never stays high for two consecutive cycles unless two consecutive frames complete, which is impossible for WIDTH ≥ 2.
- Mixing shift directions within a frame is legal; each operation counts as one.
- Reset values: pdata_out=RESET_VAL, sout_msb/sout_lsb follow from RESET_VAL, cnt=0, frame_done=0.

## Timing
- Latency: one cycle. An operation sampled at edge N is visible on pdata_out, sout_* and frame_done immediately after edge N.
- frame_done rises on the same edge that writes the result of the WIDTH-th shift. It is therefore concurrent with that result on pdata_out.
- Reset assertion mid-frame clears all state immediately, without waiting for a clock edge. Deassertion is consumed synchronously by upstream logic; the first operation is taken on the first edge with rst_n high.
- sout_msb and sout_lsb are direct wires from register bits. No combinational path exists from any input to any output.

## Structure
- Package shift_pkg:
  - mode localparams/enum (MODE_HOLD … MODE_CLR).
  - Mode field width constant (3).
- Sub-module shift_frame_counter:
  - Parameter: WIDTH.
  - Inputs: clk, rst_n, clr, inc.
  - Output: frame_done.
  - Owns cnt and the wrap logic.
- The top level holds the data register and the mode mux, and decodes clr = en & (LOAD | CLR) and inc = en & (SHL | SHR | ROL | ROR).

## Test plan
All scenarios use WIDTH=8 and RESET_VAL=0.
- Reset: LOAD 0xFF, then assert rst_n low between edges → pdata_out=0x00 and frame_done=0 immediately. Edges during reset have no effect.
- Shift: LOAD 0xA5, then SHL with sin_r=1 → 0x4B with sout_msb=0. LOAD 0xA5, then SHR with sin_l=1 → 0xD2 with sout_lsb=0.
- Rotate frame: LOAD 0x81, then 8× ROL → values 0x03, 0x06, …, 0xC0, 0x81. frame_done=1 only after the 8th edge, exactly one cycle.
- Enable/reserved: en=0 with mode=SHL for 3 cycles, then mode=7 with en=1 → pdata_out unchanged and no frame_done. The next 8 shifts still complete a frame.
- Mid-frame reload: LOAD, 5× SHL, LOAD 0x3C, 8× SHR with sin_l=0 → frame_done only after the 8th post-reload shift, not after the 3rd. Final pdata_out=0x00.
- Back-to-back frames: 16 consecutive ROR from 0x01 → frame_done on shifts 8 and 16 only. pdata_out=0x01 after each.
